// File: rtl/cpu_decode_stage.sv
// Decode stage between fetch and execute: decodes one instruction per cycle, reads the register bank, registers operands and control.
// Latency: 1 cycle from an accepted instruction to out_*. Throughput is 1/cycle with no hazard.
// Backpressure: out_ready=0 freezes out_* and deasserts in_ready. A load-use hazard inserts one bubble. Flush always accepts and drops the input.
//
// Ports:
//   clock, reset (sync, active-high), flush
//   in_valid/in_ready, in_instr, in_next_pc        : fetch side handshake and payload
//   rd_addr_a/b (out), rd_data_a/b (in)            : combinational register bank read
//   out_valid/out_ready, out_*                     : execute side handshake and registered payload
//   stall_count                                    : saturating count of cycles with in_valid && !in_ready
module cpu_decode_stage #(
  parameter int XLEN           = 32,
  parameter bit MUL_EN         = 1'b0,
  parameter bit LOAD_USE_STALL = 1'b1,
  parameter int CNT_W          = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_next_pc,
  output logic [4:0]       rd_addr_a,
  output logic [4:0]       rd_addr_b,
  input  logic [XLEN-1:0]  rd_data_a,
  input  logic [XLEN-1:0]  rd_data_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_next_pc,
  output logic [XLEN-1:0]  out_ra_data,
  output logic [XLEN-1:0]  out_rb_data,
  output logic [XLEN-1:0]  out_offset_data,
  output logic [4:0]       out_reg_dest,
  output logic [1:0]       out_alu_op,
  output logic             out_reg_b,
  output logic             out_mul,
  output logic             out_commit,
  output logic             out_mem_to_reg,
  output logic             out_reg_write,
  output logic             out_branch,
  output logic             out_illegal,
  output logic [CNT_W-1:0] stall_count
);

  // Decoded control bundle. It is carried as a single register so that
  // bubbles and flushes can clear every control bit at once.
  typedef struct packed {
    logic [1:0] alu_op;
    logic       reg_b;
    logic       mul;
    logic       commit;
    logic       mem_to_reg;
    logic       reg_write;
    logic       branch;
    logic       illegal;
  } ctrl_t;

  localparam logic [2:0] TYPE_R     = 3'b000;
  localparam logic [2:0] TYPE_M     = 3'b001;
  localparam logic [2:0] TYPE_B     = 3'b010;
  localparam logic [6:0] ISA_MUL_OP = 7'b0001000;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;

  // Instruction fields
  logic [2:0]      instr_type;
  logic [6:0]      opcode;
  logic [4:0]      src1;
  logic [4:0]      src2;
  logic [4:0]      dest;
  logic [XLEN-1:0] dec_offset;

  ctrl_t dec_ctrl;
  ctrl_t out_ctrl;

  logic advance;
  logic hazard;
  logic bubble;
  logic stall_event;

  assign instr_type = in_instr[31:29];
  assign opcode     = in_instr[31:25];
  assign src1       = in_instr[19:15];
  assign src2       = in_instr[14:10];
  assign dest       = in_instr[24:20];
  assign dec_offset = {{(XLEN-15){in_instr[14]}}, in_instr[14:0]};

  // The bank is read in the same cycle, independent of in_valid.
  assign rd_addr_a = src1;
  assign rd_addr_b = src2;

  // Decode. An illegal instruction carries only the illegal flag, so
  // execute can trap without side effects.
  always_comb begin
    dec_ctrl = '0;
    case (instr_type)
      TYPE_R: begin
        if (opcode == ISA_MUL_OP) begin
          if (MUL_EN) begin
            dec_ctrl.mul       = 1'b1;
            dec_ctrl.reg_b     = 1'b1;
            dec_ctrl.reg_write = 1'b1;
            dec_ctrl.alu_op    = ALU_ADD;
          end else begin
            dec_ctrl.illegal   = 1'b1;
          end
        end else if (in_instr[28:27] != 2'b00) begin
          dec_ctrl.illegal   = 1'b1;
        end else begin
          dec_ctrl.reg_b     = 1'b1;
          dec_ctrl.reg_write = 1'b1;
          dec_ctrl.alu_op    = in_instr[26:25];
        end
      end
      TYPE_M: begin
        dec_ctrl.alu_op     = ALU_ADD;
        dec_ctrl.commit     = 1'b1;
        dec_ctrl.mem_to_reg = 1'b1;
        dec_ctrl.reg_write  = 1'b1;
      end
      TYPE_B: begin
        dec_ctrl.branch = 1'b1;
        dec_ctrl.reg_b  = 1'b1;
        dec_ctrl.alu_op = ALU_SUB;
      end
      default: begin
        dec_ctrl.illegal = 1'b1;
      end
    endcase
  end

  // The output register can take new data when it is empty or being drained.
  assign advance = !out_valid || out_ready;

  // A load that is still in the output register cannot forward its data.
  // The consumer is held back for one cycle. src2 is only a dependency
  // when the incoming instruction actually reads register b.
  assign hazard = LOAD_USE_STALL && out_valid && out_ctrl.mem_to_reg && in_valid &&
                  ((src1 == out_reg_dest) || (dec_ctrl.reg_b && (src2 == out_reg_dest)));

  // A hazard implies out_valid, so this is the cycle the load leaves.
  assign bubble = hazard && out_ready;

  // Flush always consumes the input so fetch can redirect immediately.
  assign in_ready = !reset && (flush || (advance && !hazard));

  assign stall_event = in_valid && !in_ready;

  // Output pipeline register
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid       <= 1'b0;
      out_ctrl        <= '0;
      out_next_pc     <= '0;
      out_ra_data     <= '0;
      out_rb_data     <= '0;
      out_offset_data <= '0;
      out_reg_dest    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
    end else if (bubble) begin
      // Clearing control here drops mem_to_reg, so the hazard cannot
      // persist past this single bubble.
      out_valid <= 1'b0;
      out_ctrl  <= '0;
    end else if (advance) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_ctrl        <= dec_ctrl;
        out_next_pc     <= in_next_pc;
        out_ra_data     <= rd_data_a;
        out_rb_data     <= rd_data_b;
        out_offset_data <= dec_offset;
        out_reg_dest    <= dest;
      end
    end
  end

  // Stall counter. It sticks at all-ones instead of wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall_event && !(&stall_count)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

  assign out_alu_op     = out_ctrl.alu_op;
  assign out_reg_b      = out_ctrl.reg_b;
  assign out_mul        = out_ctrl.mul;
  assign out_commit     = out_ctrl.commit;
  assign out_mem_to_reg = out_ctrl.mem_to_reg;
  assign out_reg_write  = out_ctrl.reg_write;
  assign out_branch     = out_ctrl.branch;
  assign out_illegal    = out_ctrl.illegal;

endmodule
